mixer_pipe: RTL and testbench



---
 rtl/mixer_pipe_pkg.sv | 39 +++
 rtl/mixer_pipe_if.sv | 32 +++
 rtl/mixer_lo_gen.sv | 62 ++++++
 rtl/mixer_pipe.sv | 113 +++++++++++
 tb/tb_mixer_pipe.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/mixer_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mixer_pipe_pkg
// Description : Shared LO mode encodings, ternary LO codes, default gain and
//               a signed-saturate helper for the mixer pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
package mixer_pipe_pkg;

    typedef enum logic [1:0] {
        LO_EXT = 2'd0,
        LO_COS = 2'd1,
        LO_SIN = 2'd2,
        LO_BYP = 2'd3
    } lo_mode_e;

    localparam logic signed [1:0] LO_POS  = 2'sb01;
    localparam logic signed [1:0] LO_NEG  = 2'sb11;
    localparam logic signed [1:0] LO_ZERO = 2'sb00;

    localparam logic [15:0] AMPL_RST_DEF = 16'h2861;

    // Clamp x into the signed range of a w-bit two's-complement number.
    function automatic logic signed [63:0] sat_signed(input logic signed [63:0] x,
                                                      input int               w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (x > hi)
            return hi;
        else if (x < lo)
            return lo;
        else
            return x;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mixer_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : mixer_pipe_if
// Description : Sample, LO control, gain write and result bundle of the mixer.
// Revision    : 1.0 - initial release
// ============================================================================
interface mixer_pipe_if #(
    parameter int W  = 16,
    parameter int AW = 16
);
    logic                 in_valid;
    logic signed [W-1:0]  in_data;
    logic [1:0]           lo_ext;
    logic [1:0]           lo_mode;
    logic                 phase_sync;
    logic                 ampl_we;
    logic signed [AW-1:0] ampl_wdata;
    logic                 out_valid;
    logic signed [W-1:0]  out_data;
    logic                 ovf;

    modport master (
        output in_valid, in_data, lo_ext, lo_mode, phase_sync, ampl_we, ampl_wdata,
        input  out_valid, out_data, ovf
    );

    modport slave (
        input  in_valid, in_data, lo_ext, lo_mode, phase_sync, ampl_we, ampl_wdata,
        output out_valid, out_data, ovf
    );
endinterface
`default_nettype wire

// File: rtl/mixer_lo_gen.sv
`default_nettype none
// ============================================================================
// Module      : mixer_lo_gen
// Description : fs/4 phase counter with sync, and LO mode to ternary decode.
// Revision    : 1.0 - initial release
// ============================================================================
module mixer_lo_gen
    import mixer_pipe_pkg::*;
(
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              in_valid_i,
    input  wire logic              phase_sync_i,
    input  wire logic [1:0]        lo_mode_i,
    input  wire logic [1:0]        lo_ext_i,
    output      logic signed [1:0] lo_o
);
    logic [1:0] phase_q;
    logic [1:0] phase_d;

    // Sync wins over advance; the current sample still sees the old phase.
    always_comb begin
        phase_d = phase_q;
        if (phase_sync_i)
            phase_d = 2'd0;
        else if (in_valid_i)
            phase_d = phase_q + 2'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            phase_q <= 2'd0;
        else
            phase_q <= phase_d;
    end

    always_comb begin
        lo_o = LO_ZERO;
        case (lo_mode_i)
            LO_EXT: begin
                if (lo_ext_i[1])
                    lo_o = LO_NEG;
                else if (lo_ext_i[0])
                    lo_o = LO_POS;
            end
            LO_COS: begin
                if (phase_q == 2'd0)
                    lo_o = LO_POS;
                else if (phase_q == 2'd2)
                    lo_o = LO_NEG;
            end
            LO_SIN: begin
                if (phase_q == 2'd1)
                    lo_o = LO_POS;
                else if (phase_q == 2'd3)
                    lo_o = LO_NEG;
            end
            default: lo_o = LO_POS;
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/mixer_pipe.sv
`default_nettype none
// ============================================================================
// Module      : mixer_pipe
// Description : Two-stage LO mixer: ternary LO multiply, then gain scale with
//               sticky overflow. Define MIXER_SAT_EN for saturating overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module mixer_pipe
    import mixer_pipe_pkg::*;
#(
    parameter int            W        = 16,
    parameter int            AW       = 16,
    parameter int            FRAC     = 15,
    parameter logic [AW-1:0] AMPL_RST = AW'(AMPL_RST_DEF)
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    mixer_pipe_if.slave bus
);
    localparam logic signed [W-1:0] S_MIN = {1'b1, {(W-1){1'b0}}};
    localparam logic signed [W-1:0] S_MAX = {1'b0, {(W-1){1'b1}}};

    logic signed [1:0]      w_lo;
    logic signed [W-1:0]    w_neg;
    logic                   w_neg_ovf;
    logic signed [W-1:0]    w_s1_d;
    logic signed [W+AW-1:0] w_prod;
    logic signed [W+AW-1:0] w_shift;
    logic signed [63:0]     w_shift64;
    logic signed [63:0]     w_sat64;
    logic                   w_rng_ovf;
    logic signed [W-1:0]    w_out_d;

    logic signed [AW-1:0]   ampl_q;
    logic signed [AW-1:0]   ampl_d;
    logic signed [AW-1:0]   a1_q;
    logic signed [W-1:0]    s1_q;
    logic                   v1_q;
    logic                   out_valid_q;
    logic signed [W-1:0]    out_data_q;
    logic                   ovf_q;
    logic                   ovf_d;

    mixer_lo_gen u_lo_gen (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid_i   (bus.in_valid),
        .phase_sync_i (bus.phase_sync),
        .lo_mode_i    (bus.lo_mode),
        .lo_ext_i     (bus.lo_ext),
        .lo_o         (w_lo)
    );

    assign w_neg     = -bus.in_data;
    assign w_neg_ovf = (w_lo == LO_NEG) && (bus.in_data == S_MIN);

    always_comb begin
        w_s1_d = '0;
        if (w_lo == LO_POS)
            w_s1_d = bus.in_data;
        else if (w_lo == LO_NEG) begin
`ifdef MIXER_SAT_EN
            w_s1_d = w_neg_ovf ? S_MAX : w_neg;
`else
            w_s1_d = w_neg;
`endif
        end
    end

    assign w_prod    = (W+AW)'(s1_q) * (W+AW)'(a1_q);
    assign w_shift   = w_prod >>> FRAC;
    assign w_shift64 = 64'(w_shift);
    assign w_sat64   = sat_signed(w_shift64, W);
    assign w_rng_ovf = (w_sat64 != w_shift64);

`ifdef MIXER_SAT_EN
    assign w_out_d = W'(w_sat64);
`else
    assign w_out_d = w_shift[W-1:0];
`endif

    assign ampl_d = bus.ampl_we ? bus.ampl_wdata : ampl_q;
    assign ovf_d  = ovf_q | (bus.in_valid & w_neg_ovf) | (v1_q & w_rng_ovf);

    // Gain travels with the sample so a same-cycle write only affects later samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ampl_q      <= AMPL_RST;
            a1_q        <= '0;
            s1_q        <= '0;
            v1_q        <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            ovf_q       <= 1'b0;
        end else begin
            ampl_q      <= ampl_d;
            v1_q        <= bus.in_valid;
            if (bus.in_valid) begin
                s1_q <= w_s1_d;
                a1_q <= ampl_q;
            end
            out_valid_q <= v1_q;
            if (v1_q)
                out_data_q <= w_out_d;
            ovf_q       <= ovf_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.ovf       = ovf_q;
endmodule
`default_nettype wire

// File: tb/tb_mixer_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_mixer_pipe
// Description : Directed vector bench for mixer_pipe with streamed corner cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mixer_pipe;

    typedef struct {
        logic [1:0]  mode;
        logic [1:0]  ext;
        logic [15:0] data;
        logic        sync;
        logic        we;
        logic [15:0] wdata;
        logic [15:0] exp;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    mixer_pipe_if #(.W(16), .AW(16)) bus ();

    mixer_pipe dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [1:0] mode, input logic [1:0] ext,
                                input logic [15:0] data, input logic sync,
                                input logic we, input logic [15:0] wdata,
                                input logic [15:0] exp);
        vec_t v;
        v.mode = mode; v.ext = ext; v.data = data; v.sync = sync;
        v.we = we; v.wdata = wdata; v.exp = exp;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v, input logic valid);
        bus.in_valid   = valid;
        bus.lo_mode    = v.mode;
        bus.lo_ext     = v.ext;
        bus.in_data    = v.data;
        bus.phase_sync = v.sync;
        bus.ampl_we    = v.we;
        bus.ampl_wdata = v.wdata;
    endtask

    task automatic idle();
        bus.in_valid   = 1'b0;
        bus.phase_sync = 1'b0;
        bus.ampl_we    = 1'b0;
    endtask

    // Back-to-back samples; the result of sample i is visible two negedges later.
    task automatic run_stream(input string name, input vec_t q[$]);
        int n;
        n = q.size();
        for (int i = 0; i < n + 2; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                check($sformatf("%s[%0d].valid", name, i - 2), {31'd0, bus.out_valid}, 32'd1);
                check($sformatf("%s[%0d].data", name, i - 2), {16'd0, bus.out_data}, {16'd0, q[i-2].exp});
            end
            if (i < n)
                drive(q[i], 1'b1);
            else
                idle();
        end
    endtask

    task automatic one_cycle(input logic sync, input logic we, input logic [15:0] wdata);
        @(negedge clk);
        bus.in_valid   = 1'b0;
        bus.phase_sync = sync;
        bus.ampl_we    = we;
        bus.ampl_wdata = wdata;
    endtask

    vec_t tbl[9];
    vec_t q[$];

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.lo_ext = '0; bus.lo_mode = '0;
        bus.phase_sync = 1'b0; bus.ampl_we = 1'b0; bus.ampl_wdata = '0;

        tbl[0] = mk(2'd3, 2'b00, 16'h4000, 1'b0, 1'b0, 16'h0, 16'h1430);
        tbl[1] = mk(2'd0, 2'b10, 16'h4000, 1'b0, 1'b0, 16'h0, 16'hEBCF);
        tbl[2] = mk(2'd0, 2'b01, 16'h4000, 1'b0, 1'b0, 16'h0, 16'h1430);
        tbl[3] = mk(2'd0, 2'b00, 16'h4000, 1'b0, 1'b0, 16'h0, 16'h0000);
        tbl[4] = mk(2'd0, 2'b11, 16'h7FFF, 1'b0, 1'b0, 16'h0, 16'hD79F);
        tbl[5] = mk(2'd3, 2'b00, 16'h7FFF, 1'b0, 1'b0, 16'h0, 16'h2860);
        tbl[6] = mk(2'd3, 2'b00, 16'hFFFF, 1'b0, 1'b0, 16'h0, 16'hFFFF);
        tbl[7] = mk(2'd3, 2'b00, 16'h0001, 1'b0, 1'b0, 16'h0, 16'h0000);
        tbl[8] = mk(2'd0, 2'b10, 16'hFFFF, 1'b0, 1'b0, 16'h0, 16'h0000);

        repeat (2) @(negedge clk);
        check("rst.out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst.out_data", {16'd0, bus.out_data}, 32'd0);
        check("rst.ovf", {31'd0, bus.ovf}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            drive(tbl[i], 1'b1);
            @(negedge clk);
            idle();
            check($sformatf("tbl[%0d].early", i), {31'd0, bus.out_valid}, 32'd0);
            @(negedge clk);
            check($sformatf("tbl[%0d].valid", i), {31'd0, bus.out_valid}, 32'd1);
            check($sformatf("tbl[%0d].data", i), {16'd0, bus.out_data}, {16'd0, tbl[i].exp});
            @(negedge clk);
            check($sformatf("tbl[%0d].bubble", i), {31'd0, bus.out_valid}, 32'd0);
            check($sformatf("tbl[%0d].hold", i), {16'd0, bus.out_data}, {16'd0, tbl[i].exp});
        end
        check("ovf.clean", {31'd0, bus.ovf}, 32'd0);

        one_cycle(1'b1, 1'b0, 16'h0);
        q = {};
        for (int i = 0; i < 4; i++) begin
            logic [15:0] e;
            e = (i == 0) ? 16'h1430 : (i == 2) ? 16'hEBCF : 16'h0000;
            q.push_back(mk(2'd1, 2'b00, 16'h4000, 1'b0, 1'b0, 16'h0, e));
        end
        run_stream("cos", q);

        q = {};
        q.push_back(mk(2'd1, 2'b00, 16'h4000, 1'b0, 1'b0, 16'h0, 16'h1430));
        q.push_back(mk(2'd1, 2'b00, 16'h4000, 1'b1, 1'b0, 16'h0, 16'h0000));
        q.push_back(mk(2'd1, 2'b00, 16'h4000, 1'b0, 1'b0, 16'h0, 16'h1430));
        q.push_back(mk(2'd1, 2'b00, 16'h4000, 1'b0, 1'b0, 16'h0, 16'h0000));
        run_stream("cos_sync", q);

        one_cycle(1'b1, 1'b0, 16'h0);
        q = {};
        q.push_back(mk(2'd2, 2'b00, 16'h4000, 1'b0, 1'b0, 16'h0, 16'h0000));
        q.push_back(mk(2'd2, 2'b00, 16'h4000, 1'b0, 1'b0, 16'h0, 16'h1430));
        q.push_back(mk(2'd2, 2'b00, 16'h4000, 1'b0, 1'b0, 16'h0, 16'h0000));
        q.push_back(mk(2'd2, 2'b00, 16'h4000, 1'b0, 1'b0, 16'h0, 16'hEBCF));
        run_stream("sin", q);

        q = {};
        q.push_back(mk(2'd3, 2'b00, 16'h4000, 1'b0, 1'b1, 16'h7FFF, 16'h1430));
        q.push_back(mk(2'd3, 2'b00, 16'h4000, 1'b0, 1'b0, 16'h0, 16'h3FFF));
        run_stream("ampl_wr", q);
        check("ovf.still_clean", {31'd0, bus.ovf}, 32'd0);

        one_cycle(1'b0, 1'b1, 16'h2861);
        q = {};
`ifdef MIXER_SAT_EN
        q.push_back(mk(2'd0, 2'b11, 16'h8000, 1'b0, 1'b0, 16'h0, 16'h2860));
`else
        q.push_back(mk(2'd0, 2'b11, 16'h8000, 1'b0, 1'b0, 16'h0, 16'hD79F));
`endif
        run_stream("neg_min", q);
        check("ovf.neg_set", {31'd0, bus.ovf}, 32'd1);
        repeat (2) @(negedge clk);
        check("ovf.sticky", {31'd0, bus.ovf}, 32'd1);

        @(negedge clk);
        drive(mk(2'd1, 2'b00, 16'h4000, 1'b0, 1'b1, 16'h7FFF, 16'h0), 1'b1);
        @(negedge clk);
        drive(mk(2'd1, 2'b00, 16'h4000, 1'b0, 1'b0, 16'h0, 16'h0), 1'b1);
        @(negedge clk);
        idle();
        rst_n = 1'b0;
        #1;
        check("midrst.valid", {31'd0, bus.out_valid}, 32'd0);
        check("midrst.data", {16'd0, bus.out_data}, 32'd0);
        check("midrst.ovf", {31'd0, bus.ovf}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("midrst.flush[%0d]", i), {31'd0, bus.out_valid}, 32'd0);
        end
        q = {};
        q.push_back(mk(2'd1, 2'b00, 16'h4000, 1'b0, 1'b0, 16'h0, 16'h1430));
        q.push_back(mk(2'd1, 2'b00, 16'h4000, 1'b0, 1'b0, 16'h0, 16'h0000));
        run_stream("post_rst", q);
        check("post_rst.ovf", {31'd0, bus.ovf}, 32'd0);

        one_cycle(1'b0, 1'b1, 16'h8000);
        q = {};
`ifdef MIXER_SAT_EN
        q.push_back(mk(2'd3, 2'b00, 16'h8000, 1'b0, 1'b0, 16'h0, 16'h7FFF));
`else
        q.push_back(mk(2'd3, 2'b00, 16'h8000, 1'b0, 1'b0, 16'h0, 16'h8000));
`endif
        run_stream("range", q);
        check("ovf.range_set", {31'd0, bus.ovf}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
